regfile_dump_reader: RTL and testbench

- Read-side sequencer for the 32x32 dual-read-port register file.
- On a start pulse it walks a contiguous register range through read ports A and B, two registers per fetch.
- Fetched words are streamed out one per valid/ready handshake, each tagged with its register address.
- Used for debug dumps and for checking write sequences issued by the register-file stimulus.

---
 rtl/regfile_dump_reader.sv | 238 +++++++++++++++++++++++
 tb/tb_regfile_dump_reader.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_dump_reader.sv
// Read-side sequencer for the 32x32 dual-read-port register file.
// Latency: Start at cycle t -> FETCH at t+1 -> first Out_Valid at t+2; one bubble per fetched pair.
// Backpressure: Out_Valid/Out_Data/Out_Addr hold stable while Out_Ready is low; stalls indefinitely.
//
// Ports:
//   clk_i, rst_i               clock (rising edge), asynchronous active-high reset
//   start_i, base_addr_i,      dump request; base and count sampled only in IDLE
//   count_i                    (count 0..32, larger values clamp to 32)
//   r_addr_a_o/b_o,            register file read ports A/B (data combinational from address)
//   r_data_a_i/b_i
//   out_data_o, out_addr_o,    streamed register value and its address, valid/ready handshake
//   out_valid_o, out_ready_i
//   busy_o, done_o             busy from FETCH through DONE; done is a one-cycle pulse
//   checksum_o                 only when REGDUMP_CHECKSUM_EN is defined: XOR of all words
//                              transferred since the last accepted start
//
// Optional feature macro: REGDUMP_CHECKSUM_EN

module regfile_dump_reader #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic [ADDR_W-1:0] base_addr_i,
    input  logic [ADDR_W:0]   count_i,
    output logic [ADDR_W-1:0] r_addr_a_o,
    output logic [ADDR_W-1:0] r_addr_b_o,
    input  logic [DATA_W-1:0] r_data_a_i,
    input  logic [DATA_W-1:0] r_data_b_i,
    output logic [DATA_W-1:0] out_data_o,
    output logic [ADDR_W-1:0] out_addr_o,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic              busy_o,
`ifdef REGDUMP_CHECKSUM_EN
    output logic              done_o,
    output logic [DATA_W-1:0] checksum_o
`else
    output logic              done_o
`endif
);

    // A full dump covers every register exactly once.
    localparam logic [ADDR_W:0] MAX_CNT = (ADDR_W+1)'(1 << ADDR_W);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DRAIN0 = 3'd2,
        S_DRAIN1 = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [ADDR_W:0]   rem_q, rem_d;
    logic [DATA_W-1:0] buf0_q, buf0_d;
    logic [DATA_W-1:0] buf1_q, buf1_d;
    logic              have2_q, have2_d;
    logic [ADDR_W-1:0] raddr_a_q, raddr_a_d;
    logic [ADDR_W-1:0] raddr_b_q, raddr_b_d;

    logic [ADDR_W:0]   count_clamped;
    logic [ADDR_W-1:0] ptr_inc;
    logic              xfer;

    assign count_clamped = (count_i > MAX_CNT) ? MAX_CNT : count_i;
    // Address arithmetic wraps naturally at ADDR_W bits (31 -> 0).
    assign ptr_inc       = ptr_q + ADDR_W'(1);
    assign xfer          = out_valid_o && out_ready_i;

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= S_IDLE;
            ptr_q     <= '0;
            rem_q     <= '0;
            buf0_q    <= '0;
            buf1_q    <= '0;
            have2_q   <= 1'b0;
            raddr_a_q <= '0;
            raddr_b_q <= '0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            rem_q     <= rem_d;
            buf0_q    <= buf0_d;
            buf1_q    <= buf1_d;
            have2_q   <= have2_d;
            raddr_a_q <= raddr_a_d;
            raddr_b_q <= raddr_b_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        rem_d     = rem_q;
        buf0_d    = buf0_q;
        buf1_d    = buf1_q;
        have2_d   = have2_q;
        raddr_a_d = raddr_a_q;
        raddr_b_d = raddr_b_q;

        unique case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    ptr_d   = base_addr_i;
                    rem_d   = count_clamped;
                    state_d = (count_clamped != '0) ? S_FETCH : S_DONE;
                end
            end

            S_FETCH: begin
                // Register contents are captured only here; writes landing
                // later in the pair's drain are not seen by this dump.
                buf0_d    = r_data_a_i;
                buf1_d    = r_data_b_i;
                raddr_a_d = ptr_q;
                raddr_b_d = ptr_inc;
                have2_d   = (rem_q >= (ADDR_W+1)'(2));
                state_d   = S_DRAIN0;
            end

            S_DRAIN0: begin
                if (out_ready_i) begin
                    rem_d = rem_q - (ADDR_W+1)'(1);
                    ptr_d = ptr_inc;
                    if (have2_q) begin
                        state_d = S_DRAIN1;
                    end else if (rem_q > (ADDR_W+1)'(1)) begin
                        state_d = S_FETCH;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end

            S_DRAIN1: begin
                if (out_ready_i) begin
                    rem_d   = rem_q - (ADDR_W+1)'(1);
                    ptr_d   = ptr_inc;
                    state_d = (rem_q > (ADDR_W+1)'(1)) ? S_FETCH : S_DONE;
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    always_comb begin
        r_addr_a_o  = raddr_a_q;
        r_addr_b_o  = raddr_b_q;
        out_data_o  = '0;
        out_addr_o  = '0;
        out_valid_o = 1'b0;
        busy_o      = 1'b0;
        done_o      = 1'b0;

        unique case (state_q)
            S_IDLE: begin
            end
            S_FETCH: begin
                // Drive the pair combinationally so data is ready at this edge;
                // the stored copies keep the addresses steady afterwards.
                r_addr_a_o = ptr_q;
                r_addr_b_o = ptr_inc;
                busy_o     = 1'b1;
            end
            S_DRAIN0: begin
                out_valid_o = 1'b1;
                out_data_o  = buf0_q;
                out_addr_o  = ptr_q;
                busy_o      = 1'b1;
            end
            S_DRAIN1: begin
                // ptr_q has already advanced past the first word of the pair.
                out_valid_o = 1'b1;
                out_data_o  = buf1_q;
                out_addr_o  = ptr_q;
                busy_o      = 1'b1;
            end
            S_DONE: begin
                busy_o = 1'b1;
                done_o = 1'b1;
            end
            default: begin
            end
        endcase
    end

`ifdef REGDUMP_CHECKSUM_EN
    // ------------------------------------------------------------------
    // Running XOR of transferred words; holds after DONE until next start.
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] csum_q, csum_d;

    always_comb begin
        csum_d = csum_q;
        if (state_q == S_IDLE && start_i) begin
            csum_d = '0;
        end else if (xfer) begin
            csum_d = csum_q ^ out_data_o;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            csum_q <= '0;
        end else begin
            csum_q <= csum_d;
        end
    end

    assign checksum_o = csum_q;
`else
    // Handshake indicator only feeds the checksum when it is built in.
    logic unused_xfer;
    assign unused_xfer = xfer;
`endif

endmodule

// File: tb/tb_regfile_dump_reader.sv
module tb_regfile_dump_reader;

    logic        clk_i;
    logic        rst_i;
    logic        start_i;
    logic [4:0]  base_addr_i;
    logic [5:0]  count_i;
    logic [4:0]  r_addr_a_o;
    logic [4:0]  r_addr_b_o;
    logic [31:0] r_data_a_i;
    logic [31:0] r_data_b_i;
    logic [31:0] out_data_o;
    logic [4:0]  out_addr_o;
    logic        out_valid_o;
    logic        out_ready_i;
    logic        busy_o;
    logic        done_o;
`ifdef REGDUMP_CHECKSUM_EN
    logic [31:0] checksum_o;
`endif

    int tests;
    int fails;

    // Behavioural register file with combinational read ports.
    logic [31:0] rf [32];
    assign r_data_a_i = rf[r_addr_a_o];
    assign r_data_b_i = rf[r_addr_b_o];

    regfile_dump_reader #(.ADDR_W(5), .DATA_W(32)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .start_i     (start_i),
        .base_addr_i (base_addr_i),
        .count_i     (count_i),
        .r_addr_a_o  (r_addr_a_o),
        .r_addr_b_o  (r_addr_b_o),
        .r_data_a_i  (r_data_a_i),
        .r_data_b_i  (r_data_b_i),
        .out_data_o  (out_data_o),
        .out_addr_o  (out_addr_o),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .busy_o      (busy_o),
`ifdef REGDUMP_CHECKSUM_EN
        .done_o      (done_o),
        .checksum_o  (checksum_o)
`else
        .done_o      (done_o)
`endif
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // Results collected by run_dump (cycle numbers are relative to the Start cycle = 0).
    logic [4:0]  got_addr [$];
    logic [31:0] got_data [$];
    int          got_cyc  [$];
    logic [4:0]  fetch_a  [$];
    logic [4:0]  fetch_b  [$];
    int          first_valid;
    int          done_pulses;
    int          done_cyc;
    logic        busy_after;
    logic        done_after;
    logic        stall_ok;
    logic        timed_out;
    logic [31:0] csum_at_done;

    // Reference model output.
    logic [4:0]  exp_addr [$];
    logic [31:0] exp_data [$];
    logic [31:0] exp_csum;

    task automatic build_exp(input logic [4:0] base, input int cnt);
        int n;
        exp_addr.delete();
        exp_data.delete();
        exp_csum = 32'h0;
        n = (cnt > 32) ? 32 : cnt;
        for (int i = 0; i < n; i++) begin
            logic [4:0] a;
            a = 5'((int'(base) + i) % 32);
            exp_addr.push_back(a);
            exp_data.push_back(rf[a]);
            exp_csum = exp_csum ^ rf[a];
        end
    endtask

    // Drives one dump and records everything observed; does no checking.
    // ready_mode 0: always ready, 1: random. stall_at: hold ready low 5 cycles
    // when that many words have transferred (-1 = never). restart_at: pulse
    // Start with a different base at that cycle (-1 = never).
    task automatic run_dump(input logic [4:0] base, input logic [5:0] cnt,
                            input int ready_mode, input int stall_at, input int restart_at);
        int cyc;
        int stall_left;
        bit stall_used;
        bit seen_done;
        logic [31:0] hold_d;
        logic [4:0]  hold_a;
        got_addr.delete(); got_data.delete(); got_cyc.delete();
        fetch_a.delete(); fetch_b.delete();
        first_valid = -1; done_pulses = 0; done_cyc = -1;
        busy_after = 1'bx; done_after = 1'bx; stall_ok = 1'b1; timed_out = 1'b1;
        csum_at_done = 32'hx;
        stall_left = 0; stall_used = 0; seen_done = 0;
        hold_d = '0; hold_a = '0;

        start_i = 1'b1; base_addr_i = base; count_i = cnt; out_ready_i = 1'b1;
        @(posedge clk_i); #1;
        start_i = 1'b0;
        cyc = 0;
        while (cyc < 400) begin
            if (seen_done) begin
                busy_after = busy_o;
                done_after = done_o;
                timed_out  = 1'b0;
                break;
            end
            if (stall_at >= 0 && !stall_used && got_addr.size() == stall_at && out_valid_o) begin
                stall_used = 1; stall_left = 5;
                hold_d = out_data_o; hold_a = out_addr_o;
            end
            if (stall_left > 0) begin
                out_ready_i = 1'b0;
                if (!out_valid_o || out_data_o !== hold_d || out_addr_o !== hold_a) stall_ok = 1'b0;
                stall_left--;
            end else begin
                out_ready_i = (ready_mode == 1) ? ($urandom_range(0, 3) != 0) : 1'b1;
            end
            if (cyc == restart_at) begin
                start_i = 1'b1;
                base_addr_i = base + 5'd9;
                count_i = 6'd2;
            end else begin
                start_i = 1'b0;
            end
            if (out_valid_o && first_valid < 0) first_valid = cyc + 1;
            if (busy_o && !out_valid_o && !done_o) begin
                fetch_a.push_back(r_addr_a_o);
                fetch_b.push_back(r_addr_b_o);
            end
            if (out_valid_o && out_ready_i) begin
                got_addr.push_back(out_addr_o);
                got_data.push_back(out_data_o);
                got_cyc.push_back(cyc + 1);
            end
            if (done_o) begin
                done_pulses++;
                if (done_cyc < 0) done_cyc = cyc + 1;
                seen_done = 1;
`ifdef REGDUMP_CHECKSUM_EN
                csum_at_done = checksum_o;
`endif
            end
            @(posedge clk_i); #1;
            cyc++;
        end
        start_i = 1'b0;
        out_ready_i = 1'b0;
    endtask

    task automatic test_reset;
        rst_i = 1'b1; start_i = 1'b0; base_addr_i = '0; count_i = '0; out_ready_i = 1'b0;
        #3;
        tests++;
        if ({out_valid_o, busy_o, done_o} !== 3'b000 || r_addr_a_o !== 5'd0 || r_addr_b_o !== 5'd0
            || out_data_o !== 32'd0 || out_addr_o !== 5'd0) begin
            fails++;
            $display("FAIL reset_state: valid=%b busy=%b done=%b ra=%0d rb=%0d data=%h addr=%0d, want all 0",
                     out_valid_o, busy_o, done_o, r_addr_a_o, r_addr_b_o, out_data_o, out_addr_o);
        end
        @(posedge clk_i); #1;
        rst_i = 1'b0;
`ifdef REGDUMP_CHECKSUM_EN
        tests++;
        if (checksum_o !== 32'h0) begin
            fails++;
            $display("FAIL reset_checksum: got %h want 00000000", checksum_o);
        end
`endif
    endtask

    task automatic test_basic;
        for (int i = 0; i < 32; i++) rf[i] = $urandom;
        rf[1] = 32'h11111111; rf[2] = 32'h22222222; rf[3] = 32'h33333333;
        build_exp(5'd1, 3);
        run_dump(5'd1, 6'd3, 0, -1, -1);
        tests++;
        if (first_valid !== 2) begin
            fails++; $display("FAIL basic_latency: first valid at %0d want 2", first_valid);
        end
        tests++;
        if (got_addr !== exp_addr || got_data !== exp_data) begin
            fails++; $display("FAIL basic_words: got %0d words, want (1,11111111)(2,22222222)(3,33333333)", got_addr.size());
        end
        tests++;
        if (got_cyc.size() != 3 || got_cyc[1] - got_cyc[0] != 1 || got_cyc[2] - got_cyc[1] != 2) begin
            fails++; $display("FAIL basic_bubble: transfer cycles %p want gaps 1 then 2", got_cyc);
        end
        tests++;
        if (timed_out || got_cyc.size() != 3 || done_cyc != got_cyc[2] + 1 || done_pulses != 1) begin
            fails++; $display("FAIL basic_done: done at %0d pulses %0d timeout %b", done_cyc, done_pulses, timed_out);
        end
        tests++;
        if (busy_after !== 1'b0 || done_after !== 1'b0) begin
            fails++; $display("FAIL basic_idle: busy=%b done=%b after DONE, want 0 0", busy_after, done_after);
        end
`ifdef REGDUMP_CHECKSUM_EN
        tests++;
        if (csum_at_done !== 32'h00000000 || csum_at_done !== exp_csum) begin
            fails++; $display("FAIL csum_r1_r3: got %h want 00000000", csum_at_done);
        end
        build_exp(5'd1, 1);
        run_dump(5'd1, 6'd1, 0, -1, -1);
        tests++;
        if (csum_at_done !== 32'h11111111 || checksum_o !== 32'h11111111) begin
            fails++; $display("FAIL csum_r1: got %h / held %h want 11111111", csum_at_done, checksum_o);
        end
`endif
    endtask

    task automatic test_wrap;
        for (int i = 0; i < 32; i++) rf[i] = $urandom;
        build_exp(5'd30, 4);
        run_dump(5'd30, 6'd4, 0, -1, -1);
        tests++;
        if (got_addr !== exp_addr || got_data !== exp_data) begin
            fails++; $display("FAIL wrap_words: got addrs %p want 30 31 0 1", got_addr);
        end
        tests++;
        if (fetch_b.size() != 2 || fetch_b[0] !== 5'd31 || fetch_b[1] !== 5'd1
            || fetch_a[0] !== 5'd30 || fetch_a[1] !== 5'd0) begin
            fails++; $display("FAIL wrap_raddr: fetch A %p B %p want A 30,0 B 31,1", fetch_a, fetch_b);
        end
    endtask

    task automatic test_count_zero;
        run_dump(5'd12, 6'd0, 0, -1, -1);
        tests++;
        if (first_valid != -1 || got_addr.size() != 0 || done_cyc != 1 || done_pulses != 1 || timed_out) begin
            fails++; $display("FAIL count_zero: words %0d first_valid %0d done at %0d want 0 -1 1",
                              got_addr.size(), first_valid, done_cyc);
        end
        tests++;
        if (busy_after !== 1'b0) begin
            fails++; $display("FAIL count_zero_idle: busy=%b want 0", busy_after);
        end
`ifdef REGDUMP_CHECKSUM_EN
        tests++;
        if (csum_at_done !== 32'h0) begin
            fails++; $display("FAIL count_zero_csum: got %h want 0", csum_at_done);
        end
`endif
    endtask

    task automatic test_full_stall;
        for (int i = 0; i < 32; i++) rf[i] = $urandom;
        build_exp(5'd7, 40);
        run_dump(5'd7, 6'd40, 1, 10, 6);
        tests++;
        if (got_addr.size() != 32 || got_addr !== exp_addr || got_data !== exp_data) begin
            fails++; $display("FAIL full_words: got %0d words want 32 from base 7", got_addr.size());
        end
        tests++;
        if (!stall_ok) begin
            fails++; $display("FAIL stall_hold: output changed or dropped during 5-cycle stall, want stable");
        end
        tests++;
        if (done_pulses != 1 || timed_out || busy_after !== 1'b0) begin
            fails++; $display("FAIL full_done: pulses %0d timeout %b busy_after %b", done_pulses, timed_out, busy_after);
        end
    endtask

    task automatic test_reset_midstream;
        for (int i = 0; i < 32; i++) rf[i] = $urandom;
        start_i = 1'b1; base_addr_i = 5'd5; count_i = 6'd4; out_ready_i = 1'b1;
        @(posedge clk_i); #1; start_i = 1'b0;
        @(posedge clk_i); #1;
        @(posedge clk_i); #1;
        tests++;
        if (out_valid_o !== 1'b1 || out_addr_o !== 5'd6) begin
            fails++; $display("FAIL rst_setup: valid=%b addr=%0d want 1 6", out_valid_o, out_addr_o);
        end
        #2 rst_i = 1'b1;
        #1;
        tests++;
        if ({out_valid_o, busy_o, done_o} !== 3'b000 || r_addr_a_o !== 5'd0 || r_addr_b_o !== 5'd0) begin
            fails++; $display("FAIL async_reset: valid=%b busy=%b done=%b ra=%0d rb=%0d want all 0",
                              out_valid_o, busy_o, done_o, r_addr_a_o, r_addr_b_o);
        end
        @(negedge clk_i);
        rst_i = 1'b0;
        build_exp(5'd20, 5);
        run_dump(5'd20, 6'd5, 1, -1, -1);
        tests++;
        if (got_addr !== exp_addr || got_data !== exp_data || done_pulses != 1) begin
            fails++; $display("FAIL post_reset_dump: got %0d words pulses %0d want 5 1", got_addr.size(), done_pulses);
        end
    endtask

    task automatic test_random;
        for (int t = 0; t < 8; t++) begin
            logic [4:0] b;
            logic [5:0] c;
            for (int i = 0; i < 32; i++) rf[i] = $urandom;
            b = 5'($urandom_range(0, 31));
            c = 6'($urandom_range(0, 40));
            build_exp(b, int'(c));
            run_dump(b, c, 1, -1, -1);
            tests++;
            if (got_addr !== exp_addr || got_data !== exp_data || done_pulses != 1 || timed_out) begin
                fails++; $display("FAIL random_dump: base %0d count %0d got %0d words want %0d",
                                  b, c, got_addr.size(), exp_addr.size());
            end
`ifdef REGDUMP_CHECKSUM_EN
            tests++;
            if (csum_at_done !== exp_csum) begin
                fails++; $display("FAIL random_csum: got %h want %h", csum_at_done, exp_csum);
            end
`endif
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        for (int i = 0; i < 32; i++) rf[i] = '0;
        test_reset();
        test_basic();
        test_wrap();
        test_count_zero();
        test_full_stall();
        test_reset_midstream();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
